// File: rtl/fa16_rev_pkg.sv
// Shared types and defaults for the fa16_rev macro and its two-pass sequencer.
package fa16_rev_pkg;

    localparam int SETTLE_CYC_DEF = 2;
    localparam int TURN_CYC_DEF   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_RESP,
        ST_TURN_B,
        ST_BWD,
        ST_TURN_F
    } fa16_seq_state_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        c0;
        logic        z;
    } fa16_fwd_t;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] a_b;
        logic        c0_b;
        logic        c15;
    } fa16_bwd_t;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/fa16_rev_seq_if.sv
// Operand/result channels toward the PE plus the operand/result pins of the fa16_rev macro.
interface fa16_rev_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_c0;
    logic        in_z;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_s;
    logic [15:0] out_a_b;
    logic        out_c0_b;
    logic        out_c15;

    logic        dir;
    logic [15:0] f_a;
    logic [15:0] f_b;
    logic        f_c0_f;
    logic        f_z;
    logic [15:0] f_s;
    logic [15:0] f_a_b;
    logic        f_c0_b;
    logic        f_c15;

    logic [15:0] r_s;
    logic [15:0] r_a_b;
    logic        r_c0_b;
    logic        r_c15;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_c0_f;
    logic        r_z;

    // master is the sequencer; slave is the PE datapath plus the macro.
    modport master (
        input  in_valid, in_a, in_b, in_c0, in_z, out_ready,
        input  f_s, f_a_b, f_c0_b, f_c15, r_a, r_b, r_c0_f, r_z,
        output in_ready, out_valid, out_s, out_a_b, out_c0_b, out_c15,
        output dir, f_a, f_b, f_c0_f, f_z, r_s, r_a_b, r_c0_b, r_c15
    );

    modport slave (
        output in_valid, in_a, in_b, in_c0, in_z, out_ready,
        output f_s, f_a_b, f_c0_b, f_c15, r_a, r_b, r_c0_f, r_z,
        input  in_ready, out_valid, out_s, out_a_b, out_c0_b, out_c15,
        input  dir, f_a, f_b, f_c0_f, f_z, r_s, r_a_b, r_c0_b, r_c15
    );
endinterface

// File: rtl/fa16_rev_seq_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module fa16_rev_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/fa16_rev_seq.sv
// Two-pass sequencer for fa16_rev: forward compute, result handshake, backward uncompute
// with operand recovery check, and turnaround gaps around every dir flip.
module fa16_rev_seq
    import fa16_rev_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int TURN_CYC   = TURN_CYC_DEF,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    fa16_rev_seq_if.master   bus,
    output logic             busy,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int TMR_W = $clog2(max_int(SETTLE_CYC, TURN_CYC) + 1);

    fa16_seq_state_e  state;
    fa16_fwd_t        f_q;
    fa16_fwd_t        op_q;
    fa16_fwd_t        in_op;
    fa16_fwd_t        rec;
    fa16_bwd_t        r_q;
    fa16_bwd_t        res_q;
    fa16_bwd_t        f_res;
    logic             dir_q;
    logic             out_valid_q;
    logic             tmr_load;
    logic             tmr_done;
    logic [TMR_W-1:0] tmr_val;

    assign in_op = '{a: bus.in_a, b: bus.in_b, c0: bus.in_c0, z: bus.in_z};
    assign f_res = '{s: bus.f_s, a_b: bus.f_a_b, c0_b: bus.f_c0_b, c15: bus.f_c15};
    assign rec   = '{a: bus.r_a, b: bus.r_b, c0: bus.r_c0_f, z: bus.r_z};

    // Timer reloads on each transition into a timed state; it runs down during that state.
    // NOTE: both outputs get a default first so no path through the case leaves a latch.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: if (bus.in_valid) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SETTLE_CYC - 1);
            end
            ST_RESP: if (bus.out_ready) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TURN_CYC - 1);
            end
            ST_TURN_B: if (tmr_done) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SETTLE_CYC - 1);
            end
            ST_BWD: if (tmr_done) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TURN_CYC - 1);
            end
            default: ;
        endcase
    end

    fa16_rev_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // f_q/r_q only change on edges where dir_q holds, so the macro pins settle before a flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand/result copies are cleared as well, so every output reads 0 after reset.
            state       <= ST_IDLE;
            f_q         <= '0;
            op_q        <= '0;
            r_q         <= '0;
            res_q       <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            // NOTE: nonblocking default low makes err_pulse a single-cycle strobe.
            err_pulse <= 1'b0;
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    f_q   <= in_op;
                    op_q  <= in_op;
                    state <= ST_FWD;
                end
                ST_FWD: if (tmr_done) begin
                    res_q       <= f_res;
                    out_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: if (bus.out_ready) begin
                    r_q         <= res_q;
                    f_q         <= '0;
                    out_valid_q <= 1'b0;
                    state       <= ST_TURN_B;
                end
                ST_TURN_B: if (tmr_done) begin
                    dir_q <= 1'b1;
                    state <= ST_BWD;
                end
                ST_BWD: if (tmr_done) begin
                    if (rec != op_q) begin
                        err_pulse <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    end
                    r_q   <= '0;
                    state <= ST_TURN_F;
                end
                ST_TURN_F: if (tmr_done) begin
                    dir_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (state != ST_IDLE);
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.dir       = dir_q;

    assign bus.f_a       = f_q.a;
    assign bus.f_b       = f_q.b;
    assign bus.f_c0_f    = f_q.c0;
    assign bus.f_z       = f_q.z;

    assign bus.r_s       = r_q.s;
    assign bus.r_a_b     = r_q.a_b;
    assign bus.r_c0_b    = r_q.c0_b;
    assign bus.r_c15     = r_q.c15;

    assign bus.out_s     = res_q.s;
    assign bus.out_a_b   = res_q.a_b;
    assign bus.out_c0_b  = res_q.c0_b;
    assign bus.out_c15   = res_q.c15;
endmodule

// File: doc/fa16_rev_seq.md
# fa16_rev_seq

Sequencer for the bidirectional reversible 16-bit adder (`fa16_rev`). It runs each operation in two passes: a forward compute pass, then a backward uncompute pass that restores the macro's inputs. It owns the `dir` control, inserts turnaround gaps so operand pins are stable before `dir` flips, and checks that the backward pass recovers the original operands. It sits between the PE datapath (valid/ready operand and result channels) and the `fa16_rev` instance.

## Interface
- `SETTLE_CYC`, default 2: cycles each pass is driven before sampling; must be ≥1.
- `TURN_CYC`, default 1: cycles with new-direction operands loaded before `dir` flips; must be ≥1.
- `ERR_W`, default 8: width of the mismatch counter.

Clocking: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  high only in IDLE.
- `in_a`, `in_b`  in  16  operands.
- `in_c0`, `in_z`  in  1  carry-in and ancilla.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result accepted.
- `out_s`, `out_a_b`  out  16  sum and garbage copy.
- `out_c0_b`, `out_c15`  out  1  carry garbage and carry-out.
- `dir`  out  1  0 = forward, 1 = backward (registered).
- `f_a`, `f_b`  out  16; `f_c0_f`, `f_z`  out  1: forward operands (registered).
- `f_s`, `f_a_b`  in  16; `f_c0_b`, `f_c15`  in  1: forward results.
- `r_s`, `r_a_b`  out  16; `r_c0_b`, `r_c15`  out  1: backward operands (registered).
- `r_a`, `r_b`  in  16; `r_c0_f`, `r_z`  in  1: recovered operands.
- `busy`  out  1  high whenever the state is not IDLE.
- `err_pulse`  out  1  one-cycle pulse on backward mismatch.
- `err_cnt`  out  `ERR_W`  saturating mismatch count.

## Operation
- Reset value of every output is 0, except `in_ready`, which is 1. The state is IDLE.
- States: IDLE → FWD → RESP → TURN_B → BWD → TURN_F → IDLE.
- **IDLE:** `dir`=0 and `in_ready`=1.
  - On `in_valid`&&`in_ready`, load `f_*` from `in_*` and latch a copy of the operands in `op_q`.
  - Go to FWD.
- **FWD:** `dir`=0 for `SETTLE_CYC` cycles.
  - On the last cycle, capture `f_s`/`f_a_b`/`f_c0_b`/`f_c15` into the `out_*` registers.
  - Go to RESP.
- **RESP:** `out_valid`=1 and `out_*` are held stable.
  - On `out_ready`, load `r_*` from the captured results and clear `f_*` to 0.
  - Go to TURN_B.
- **TURN_B:** `dir` stays 0 for `TURN_CYC` cycles while `r_*` are stable. On exit, `dir`←1 and the state goes to BWD.
- **BWD:** `dir`=1 for `SETTLE_CYC` cycles.
  - On the last cycle, compare {`r_a`,`r_b`,`r_c0_f`,`r_z`} with `op_q`.
  - On mismatch, `err_pulse`=1 on the next cycle and `err_cnt` increments, saturating at all-ones.
  - Go to TURN_F.
- **TURN_F:** clear `r_*` to 0 and hold `dir`=1 for `TURN_CYC` cycles. On exit, `dir`←0 and the state goes to IDLE.
- `out_*` keep the last result until the next FWD capture; `out_valid` is 0 outside RESP.
- A reset in any state returns to IDLE with all outputs at their reset values. The in-flight op is dropped and `err_cnt` is cleared.
- `in_valid` while busy is ignored, because `in_ready`=0. `out_ready` outside RESP is ignored.

## Timing
- If the operand handshake is at cycle T:
  - `f_*` are valid from T+1.
  - `out_valid` rises at T+1+`SETTLE_CYC`; with defaults, at T+3.
- If the result handshake is at cycle U:
  - TURN_B covers U+1 .. U+`TURN_CYC`.
  - `dir`=1 from U+1+`TURN_CYC`.
  - The compare happens in cycle U+`TURN_CYC`+`SETTLE_CYC`.
  - `err_pulse` fires in the following cycle.
- `dir` changes only on the TURN_B→BWD and TURN_F→IDLE edges; `f_*`/`r_*` never change on the same edge that `dir` changes.
- With `out_ready` tied high, the minimum op-to-op period is 2 + 2·`SETTLE_CYC` + 2·`TURN_CYC` cycles; with defaults, 8.
- `in_ready` rises on the first IDLE cycle. A new handshake in that same cycle is legal.

## Structure
- Shared package `fa16_rev_pkg` holds:
  - the state enum `fa16_seq_state_e`;
  - `fa16_fwd_t` = {a, b, c0, z};
  - `fa16_bwd_t` = {s, a_b, c0_b, c15};
  - default constants for `SETTLE_CYC` and `TURN_CYC`.
- One sub-module, `fa16_rev_seq_timer`: a loadable down-counter with a `done` flag, shared by the FWD, BWD and TURN states.
- The sequencer does not instantiate `fa16_rev`; the PE top connects them.

## Test plan
- a=0x1234, b=0x0FF0, c0=0, z=0 → `out_s`=0x2224, `out_a_b`=0x1234, `out_c15`=0; no `err_pulse`; `out_valid` at T+3.
- a=0xFFFF, b=0x0001, c0=1 → `out_s`=0x0001, `out_c15`=1; backward pass recovers the operands and `err_cnt` stays 0.
- Stall `out_ready` low for 5 cycles → `out_*` stable and `dir` stays 0 throughout; `dir`=1 exactly `TURN_CYC`+1 cycles after the handshake.
- Model forces `r_a`=0x0000 during BWD → one `err_pulse`, `err_cnt`=1. With `ERR_W`=2, 5 forced errors → `err_cnt`=3.
- Assert `rst` mid-BWD → next cycle: IDLE, `dir`=0, `in_ready`=1, all `f_*`/`r_*`/`out_*` = 0.
- Back-to-back ops with `out_ready`=1 → period of exactly 8 cycles; a checker confirms no cycle where `dir` and the active operand bus change together.
